stack_sequencer: RTL

//  Multi-cycle controller for the stack CPU datapath (stack register, 16x4 RAM, ALU result latch).

---
 rtl/stack_sequencer_pkg.sv | 45 ++++
 rtl/stack_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer_pkg.sv
// Shared constants for the stack CPU sequencer.
//   - opcode codes (OP_NOP..OP_DUP); codes 8-15 behave as NOP
//   - stack_sel push-source codes (SEL_IMM, SEL_RAM, SEL_ALU, SEL_TOP)
//   - FSM state encoding (ST_IDLE, ST_EXEC)
//   - per-opcode helpers: minimum stack depth needed, and index of the last step
package stack_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_SAVE = 4'd3;
  localparam logic [3:0] OP_LOAD = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_DUP  = 4'd7;

  localparam logic [1:0] SEL_IMM = 2'd0;
  localparam logic [1:0] SEL_RAM = 2'd1;
  localparam logic [1:0] SEL_ALU = 2'd2;
  localparam logic [1:0] SEL_TOP = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Minimum stack occupancy an opcode needs to run without underflow.
  function automatic logic [1:0] op_need(input logic [3:0] op);
    case (op)
      OP_POP, OP_LOAD, OP_DUP: op_need = 2'd1;
      OP_SAVE, OP_ADD, OP_SUB: op_need = 2'd2;
      default:                 op_need = 2'd0;
    endcase
  endfunction

  // Index of the final execute step (E0 = 0).
  function automatic logic [1:0] op_last(input logic [3:0] op);
    case (op)
      OP_SAVE, OP_LOAD: op_last = 2'd2;
      OP_ADD, OP_SUB:   op_last = 2'd3;
      default:          op_last = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Multi-cycle controller for the stack CPU datapath.
// Accepts one opcode + immediate per op_valid/op_ready handshake, then walks
// steps E0..En emitting Moore strobes decoded from {op, step}.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   op, imm          opcode and immediate, sampled on handshake
//   op_valid         requester has an op
//   op_ready         high only in IDLE
//   stack_push/pop   stack strobes (never together)
//   stack_sel        push source, held for every step of the op, 0 in IDLE
//   imm_q            registered immediate
//   ram_addr_load    RAM address <= top of stack
//   ram_write        RAM[addr] <= top of stack
//   alu_latch        ALU latch <= v1 op v0
//   alu_sub          subtract select, meaningful with alu_latch
//   depth            current stack occupancy
//   err              sticky refused-op flag, cleared only by rst
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   op,
  input  logic [DW-1:0]                imm,
  input  logic                         op_valid,
  output logic                         op_ready,
  output logic                         stack_push,
  output logic                         stack_pop,
  output logic [1:0]                   stack_sel,
  output logic [DW-1:0]                imm_q,
  output logic                         ram_addr_load,
  output logic                         ram_write,
  output logic                         alu_latch,
  output logic                         alu_sub,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err
);

  localparam int DEPTH_W = $clog2(DEPTH+1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  state_e               state_q, state_d;
  logic [1:0]           step_q, step_d;
  logic [3:0]           op_q, op_d;
  logic [DEPTH_W-1:0]   depth_q;
  logic                 accept;
  logic                 refuse;

  assign accept = op_valid && op_ready;
  assign depth  = depth_q;

  // Guard evaluated against the depth at the accept edge; a refused op
  // still handshakes but runs as a single NOP step.
  always_comb begin
    refuse = (depth_q < DEPTH_W'(op_need(op))) ||
             (((op == OP_PUSH) || (op == OP_DUP)) && (depth_q == DEPTH_MAX));
  end

  // State register plus the registers that follow the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      depth_q <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      if (accept) begin
        imm_q <= imm;
        if (refuse) err <= 1'b1;
      end
      if (stack_push)     depth_q <= depth_q + 1'b1;
      else if (stack_pop) depth_q <= depth_q - 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXEC;
          step_d  = 2'd0;
          op_d    = (refuse || op[3]) ? OP_NOP : op;
        end
      end
      ST_EXEC: begin
        if (step_q == op_last(op_q)) begin
          state_d = ST_IDLE;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  // Moore output decode on {op, step}.
  always_comb begin
    op_ready      = (state_q == ST_IDLE);
    stack_push    = 1'b0;
    stack_pop     = 1'b0;
    stack_sel     = SEL_IMM;
    ram_addr_load = 1'b0;
    ram_write     = 1'b0;
    alu_latch     = 1'b0;
    alu_sub       = 1'b0;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_PUSH: begin
          stack_push = 1'b1;
        end
        OP_POP: begin
          stack_pop = 1'b1;
        end
        OP_SAVE: begin
          case (step_q)
            2'd0: begin
              ram_addr_load = 1'b1;
              stack_pop     = 1'b1;
            end
            2'd1:    ram_write = 1'b1;
            2'd2:    stack_pop = 1'b1;
            default: ;
          endcase
        end
        OP_LOAD: begin
          stack_sel = SEL_RAM;
          case (step_q)
            2'd0: begin
              ram_addr_load = 1'b1;
              stack_pop     = 1'b1;
            end
            // step 1 waits out the RAM read latency
            2'd2:    stack_push = 1'b1;
            default: ;
          endcase
        end
        OP_ADD, OP_SUB: begin
          stack_sel = SEL_ALU;
          case (step_q)
            2'd0: begin
              alu_latch = 1'b1;
              alu_sub   = (op_q == OP_SUB);
            end
            2'd1:    stack_pop  = 1'b1;
            2'd2:    stack_pop  = 1'b1;
            2'd3:    stack_push = 1'b1;
            default: ;
          endcase
        end
        OP_DUP: begin
          stack_sel  = SEL_TOP;
          stack_push = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
